loader_sink: RTL

LOADER_SINK -- requirements
Module: loader_sink

---
 rtl/pc88_ldr_pkg.sv | 18 +
 rtl/ldr_tmo_cnt.sv | 27 ++
 rtl/loader_sink.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/pc88_ldr_pkg.sv
// Shared types for the loader sink: FSM states, default address width, byte-enable codes.
package pc88_ldr_pkg;
  localparam int LDR_ADR_W_DEF = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } ldr_state_e;

  localparam logic [1:0] BE_LO = 2'b01;
  localparam logic [1:0] BE_HI = 2'b10;

  // Odd byte addresses land in the high half of the 16-bit word.
  function automatic logic [1:0] be_of(input logic a0);
    return a0 ? BE_HI : BE_LO;
  endfunction
endpackage

// File: rtl/ldr_tmo_cnt.sv
// Write-phase watchdog: counts enabled cycles, flags expiry in the TMO_CYC-th one.
module ldr_tmo_cnt #(
  parameter int TMO_CYC = 1023
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expired = en && (cnt_q == W'(TMO_CYC - 1));
endmodule

// File: rtl/loader_sink.sv
// Byte-download sink: four-phase loader handshake to 16-bit memory writes.
// Optional running checksum output enabled by LOADER_CHECKSUM_EN.
module loader_sink
  import pc88_ldr_pkg::*;
#(
  parameter int ADR_W   = LDR_ADR_W_DEF,
  parameter int TMO_CYC = 1023
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ldr_oe,
  input  logic             ldr_wr,
  input  logic [ADR_W-1:0] ldr_adr,
  input  logic [7:0]       ldr_wdat,
  input  logic             ldr_done,
  output logic             ldr_ack,
  output logic             mem_req,
  output logic [ADR_W-2:0] mem_adr,
  output logic [15:0]      mem_dat,
  output logic [1:0]       mem_be,
  input  logic             mem_ack,
  output logic [ADR_W:0]   byte_cnt,
`ifdef LOADER_CHECKSUM_EN
  output logic [15:0]      cksum,
`endif
  output logic             err_tmo,
  output logic             busy
);
  ldr_state_e       state_q, state_d;
  logic             ack_q, ack_d, req_q, req_d;
  logic [ADR_W-2:0] adr_q, adr_d;
  logic [15:0]      dat_q, dat_d;
  logic [1:0]       be_q, be_d;
  logic [ADR_W:0]   cnt_q, cnt_d;
  logic             err_q, err_d, oe_q, pend_q, pend_d;
  logic             tmo_clr, tmo_en, tmo_exp, oe_rise, clr_now, inc;
`ifdef LOADER_CHECKSUM_EN
  logic [15:0]      cks_q, cks_d;
`endif

  ldr_tmo_cnt #(.TMO_CYC(TMO_CYC)) u_tmo (
    .clk_sys(clk_sys), .reset(reset), .clr(tmo_clr), .en(tmo_en), .expired(tmo_exp)
  );

  assign oe_rise = ldr_oe && !oe_q;

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    req_d   = req_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    be_d    = be_q;
    err_d   = err_q;
    pend_d  = pend_q;
    tmo_clr = 1'b1;
    tmo_en  = 1'b0;
    clr_now = 1'b0;
    inc     = 1'b0;
    // An open-window edge while busy is deferred until the FSM is back in IDLE.
    if (oe_rise) begin
      if (state_q == IDLE) clr_now = 1'b1;
      else                 pend_d  = 1'b1;
    end
    case (state_q)
      IDLE: if (ldr_oe && ldr_wr && !ldr_done) begin
        state_d = WRITE;
        req_d   = 1'b1;
        adr_d   = ldr_adr[ADR_W-1:1];
        dat_d   = {ldr_wdat, ldr_wdat};
        be_d    = be_of(ldr_adr[0]);
      end
      WRITE: begin
        tmo_clr = 1'b0;
        tmo_en  = 1'b1;
        if (mem_ack || tmo_exp) begin
          state_d = ACK;
          req_d   = 1'b0;
          ack_d   = 1'b1;
          if (mem_ack) inc   = 1'b1;
          else         err_d = 1'b1;
        end
      end
      ACK: if (!ldr_wr) begin
        state_d = IDLE;
        ack_d   = 1'b0;
        if (pend_d) begin
          clr_now = 1'b1;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr_now) err_d = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
`ifdef LOADER_CHECKSUM_EN
    cks_d = cks_q;
`endif
    if (clr_now) begin
      cnt_d = '0;
`ifdef LOADER_CHECKSUM_EN
      cks_d = '0;
`endif
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
      cks_d = cks_q + {8'h00, dat_q[7:0]};
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      oe_q    <= 1'b0;
      pend_q  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      cks_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      oe_q    <= ldr_oe;
      pend_q  <= pend_d;
`ifdef LOADER_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  assign ldr_ack  = ack_q;
  assign mem_req  = req_q;
  assign mem_adr  = adr_q;
  assign mem_dat  = dat_q;
  assign mem_be   = be_q;
  assign byte_cnt = cnt_q;
  assign err_tmo  = err_q;
  assign busy     = (state_q != IDLE);
`ifdef LOADER_CHECKSUM_EN
  assign cksum    = cks_q;
`endif
endmodule
